// File: rtl/ball_ctrl.sv
// ball_ctrl: per-frame pong ball motion, wall/paddle bounce,
// miss detection with point pulses and timed re-serve from centre.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module ball_ctrl #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 10,
  parameter int PADDLE_W       = 10,
  parameter int PADDLE_H       = 80,
  parameter int LEFT_PADDLE_X  = 20,
  parameter int RIGHT_PADDLE_X = 610,
  parameter int SPEED          = 2,
  parameter int START_X        = 315,
  parameter int START_Y        = 235,
  parameter int SERVE_DELAY    = 60
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                frame_tick_i,
  input  logic [`Y_POS_W-1:0] paddle_l_y_i,
  input  logic [`Y_POS_W-1:0] paddle_r_y_i,
  output logic [`X_POS_W-1:0] ball_x_o,
  output logic [`Y_POS_W-1:0] ball_y_o,
  output logic                point_l_o,
  output logic                point_r_o,
  output logic                in_play_o
);

  localparam int XW = `X_POS_W;
  localparam int YW = `Y_POS_W;
  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [0:0] S_SERVE = 1'b0;
  localparam logic [0:0] S_PLAY  = 1'b1;

  localparam logic [XW:0] X_BS = (XW+1)'(BALL_SIZE);
  localparam logic [XW:0] X_SP = (XW+1)'(SPEED);
  localparam logic [XW:0] X_W  = (XW+1)'(SCREEN_W);
  localparam logic [XW:0] X_LR = (XW+1)'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [XW:0] X_RL = (XW+1)'(RIGHT_PADDLE_X);
  localparam logic [YW:0] Y_BS = (YW+1)'(BALL_SIZE);
  localparam logic [YW:0] Y_SP = (YW+1)'(SPEED);
  localparam logic [YW:0] Y_H  = (YW+1)'(SCREEN_H);
  localparam logic [YW:0] Y_PH = (YW+1)'(PADDLE_H);

  logic [0:0]    state;
  logic          dir_x;
  logic          dir_y;
  logic [CW-1:0] serve_cnt;

  logic [XW:0] bx;
  logic [YW:0] by;
  logic [YW:0] pl_y;
  logic [YW:0] pr_y;

  assign bx   = {1'b0, ball_x_o};
  assign by   = {1'b0, ball_y_o};
  assign pl_y = {1'b0, paddle_l_y_i};
  assign pr_y = {1'b0, paddle_r_y_i};

  logic ov_l, ov_r;
  logic hit_l, hit_r;
  logic miss_l, miss_r;
  logic floor_hit, ceil_hit;

  // Bounds kept on the ball side as sums so nothing wraps.
  assign ov_l = (by + Y_BS > pl_y) && (by < pl_y + Y_PH);
  assign ov_r = (by + Y_BS > pr_y) && (by < pr_y + Y_PH);

  assign hit_l = !dir_x && (bx >= X_LR)
              && (bx <= X_LR + X_SP) && ov_l;
  assign hit_r = dir_x && (bx + X_BS <= X_RL)
              && (bx + X_BS + X_SP >= X_RL) && ov_r;

  assign miss_l = !dir_x && !hit_l && (bx < X_SP);
  assign miss_r = dir_x && !hit_r
               && (bx + X_BS + X_SP > X_W);

  assign floor_hit = by + Y_BS + Y_SP >= Y_H;
  assign ceil_hit  = by <= Y_SP;

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          ndx;
  logic          ndy;

  always_comb begin
    nx  = ball_x_o;
    ndx = dir_x;
    if (hit_l) begin
      nx  = XW'(X_LR);
      ndx = 1'b1;
    end else if (hit_r) begin
      nx  = XW'(X_RL - X_BS);
      ndx = 1'b0;
    end else if (dir_x) begin
      nx = ball_x_o + XW'(SPEED);
    end else begin
      nx = ball_x_o - XW'(SPEED);
    end
  end

  always_comb begin
    ny  = ball_y_o;
    ndy = dir_y;
    if (dir_y) begin
      if (floor_hit) begin
        ny  = YW'(Y_H - Y_BS);
        ndy = 1'b0;
      end else begin
        ny = ball_y_o + YW'(SPEED);
      end
    end else begin
      if (ceil_hit) begin
        ny  = '0;
        ndy = 1'b1;
      end else begin
        ny = ball_y_o - YW'(SPEED);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ball_x_o  <= XW'(START_X);
      ball_y_o  <= YW'(START_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      state     <= S_SERVE;
      serve_cnt <= '0;
      point_l_o <= 1'b0;
      point_r_o <= 1'b0;
    end else begin
      point_l_o <= 1'b0;
      point_r_o <= 1'b0;
      if (frame_tick_i) begin
        if (state == S_SERVE) begin
          if (serve_cnt == CW'(SERVE_DELAY - 1)) begin
            serve_cnt <= '0;
            state     <= S_PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end else if (miss_l || miss_r) begin
          // Serve goes toward the player who just conceded.
          ball_x_o  <= XW'(START_X);
          ball_y_o  <= YW'(START_Y);
          dir_x     <= miss_r;
          dir_y     <= 1'b1;
          state     <= S_SERVE;
          serve_cnt <= '0;
          point_r_o <= miss_l;
          point_l_o <= miss_r;
        end else begin
          ball_x_o <= nx;
          ball_y_o <= ny;
          dir_x    <= ndx;
          dir_y    <= ndy;
        end
      end
    end
  end

  assign in_play_o = (state == S_PLAY);

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed literal checks plus randomized play,
// compared every cycle against an integer reference model.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module tb_ball_ctrl;

  localparam int SW  = 640;
  localparam int SH  = 480;
  localparam int BS  = 10;
  localparam int PW  = 10;
  localparam int PH  = 80;
  localparam int LPX = 20;
  localparam int RPX = 610;
  localparam int SP  = 2;
  localparam int SX  = 315;
  localparam int SY  = 235;
  localparam int SD  = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                tick = 1'b0;
  logic [`Y_POS_W-1:0] pl_y = '0;
  logic [`Y_POS_W-1:0] pr_y = '0;
  logic [`X_POS_W-1:0] ball_x;
  logic [`Y_POS_W-1:0] ball_y;
  logic                point_l;
  logic                point_r;
  logic                in_play;

  int n_cmp = 0;
  int n_bad = 0;

  ball_ctrl #(.SERVE_DELAY(SD)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .frame_tick_i (tick),
    .paddle_l_y_i (pl_y),
    .paddle_r_y_i (pr_y),
    .ball_x_o     (ball_x),
    .ball_y_o     (ball_y),
    .point_l_o    (point_l),
    .point_r_o    (point_r),
    .in_play_o    (in_play)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model in plain integers
  int m_x, m_y, m_dx, m_dy, m_play, m_cnt, m_pl, m_pr;
  bit m_ok = 1'b0;

  always @(posedge clk) begin : model
    int nx, ny, dx, dy, ql, qr, edge_r;
    bit ovl, ovr, lost_l, lost_r;
    if (!rst_n) begin
      m_x    <= SX;
      m_y    <= SY;
      m_dx   <= 1;
      m_dy   <= 1;
      m_play <= 0;
      m_cnt  <= 0;
      m_pl   <= 0;
      m_pr   <= 0;
      m_ok   <= 1'b1;
    end else begin
      m_pl <= 0;
      m_pr <= 0;
      if (tick && m_play == 0) begin
        if (m_cnt + 1 == SD) begin
          m_cnt  <= 0;
          m_play <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (tick) begin
        ql = int'(pl_y);
        qr = int'(pr_y);
        dx = m_dx;
        dy = m_dy;
        nx = m_x;
        ny = m_y;
        lost_l = 1'b0;
        lost_r = 1'b0;
        if (m_dy == 1) begin
          if (SH - (m_y + BS) <= SP) begin
            ny = SH - BS;
            dy = 0;
          end else ny = m_y + SP;
        end else begin
          if (m_y - SP <= 0) begin
            ny = 0;
            dy = 1;
          end else ny = m_y - SP;
        end
        ovl = (m_y + BS > ql) && (m_y < ql + PH);
        ovr = (m_y + BS > qr) && (m_y < qr + PH);
        edge_r = m_x + BS;
        if (m_dx == 0) begin
          if (ovl && m_x >= LPX + PW
              && m_x - (LPX + PW) <= SP) begin
            nx = LPX + PW;
            dx = 1;
          end else if (m_x - SP < 0) lost_l = 1'b1;
          else nx = m_x - SP;
        end else begin
          if (ovr && edge_r <= RPX && RPX - edge_r <= SP) begin
            nx = RPX - BS;
            dx = 0;
          end else if (edge_r + SP > SW) lost_r = 1'b1;
          else nx = m_x + SP;
        end
        if (lost_l || lost_r) begin
          m_x    <= SX;
          m_y    <= SY;
          m_dx   <= lost_r ? 1 : 0;
          m_dy   <= 1;
          m_play <= 0;
          m_cnt  <= 0;
          m_pr   <= lost_l ? 1 : 0;
          m_pl   <= lost_r ? 1 : 0;
        end else begin
          m_x  <= nx;
          m_y  <= ny;
          m_dx <= dx;
          m_dy <= dy;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("x", int'(ball_x), m_x);
      chk("y", int'(ball_y), m_y);
      chk("point_l", int'(point_l), m_pl);
      chk("point_r", int'(point_r), m_pr);
      chk("in_play", int'(in_play), m_play);
    end
  end

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    int t;
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b1;
    pl_y  = 10'd900;
    pr_y  = 10'd400;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    chk("rst_x", int'(ball_x), 315);
    chk("rst_y", int'(ball_y), 235);
    chk("rst_pl", int'(point_l), 0);
    chk("rst_pr", int'(point_r), 0);
    chk("rst_play", int'(in_play), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_tick();
    chk("serve1_play", int'(in_play), 0);
    do_tick();
    chk("serve2_play", int'(in_play), 0);
    do_tick();
    chk("serve3_play", int'(in_play), 1);
    chk("serve3_x", int'(ball_x), 315);
    repeat (5) @(negedge clk);
    chk("hold_x", int'(ball_x), 315);
    chk("hold_y", int'(ball_y), 235);
    do_tick();
    chk("move1_x", int'(ball_x), 317);
    chk("move1_y", int'(ball_y), 237);

    repeat (116) do_tick();
    chk("pre_floor_y", int'(ball_y), 469);
    do_tick();
    chk("floor_x", int'(ball_x), 551);
    chk("floor_y", int'(ball_y), 470);
    do_tick();
    chk("floor2_y", int'(ball_y), 468);
    repeat (23) do_tick();
    do_tick();
    chk("rhit_x", int'(ball_x), 600);
    chk("rhit_y", int'(ball_y), 420);

    repeat (300) do_tick();
    chk("edge_x", int'(ball_x), 0);
    do_tick();
    chk("miss_pr", int'(point_r), 1);
    chk("miss_pl", int'(point_l), 0);
    chk("miss_x", int'(ball_x), 315);
    chk("miss_y", int'(ball_y), 235);
    chk("miss_play", int'(in_play), 0);
    @(negedge clk);
    chk("miss_pr_clr", int'(point_r), 0);
    repeat (3) do_tick();
    do_tick();
    chk("reserve_x", int'(ball_x), 313);
    chk("reserve_y", int'(ball_y), 237);

    rst_n = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick  = 1'b0;
    chk("mrst_x", int'(ball_x), 315);
    chk("mrst_y", int'(ball_y), 235);
    chk("mrst_play", int'(in_play), 0);
    chk("mrst_pr", int'(point_r), 0);

    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      tick  = ($urandom_range(0, 1) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 9) < 7) begin
        t = m_y - int'($urandom_range(0, 75));
        if (t < 0) t = 0;
        pl_y = `Y_POS_W'(t);
      end else begin
        pl_y = `Y_POS_W'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 9) < 7) begin
        t = m_y - int'($urandom_range(0, 75));
        if (t < 0) t = 0;
        pr_y = `Y_POS_W'(t);
      end else begin
        pr_y = `Y_POS_W'($urandom_range(0, 1023));
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
